// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: reset vector, ROM geometry,
// special instruction encodings and instruction field helpers.
package mips_pkg;

    localparam logic [31:0] RESET_PC     = 32'h0040_0000;
    localparam int          ADRS_W       = 9;
    localparam logic [31:0] INST_NOP     = 32'h0000_0000;
    localparam logic [31:0] INST_SYSCALL = 32'h0000_000c;

    function automatic logic [5:0] opcode(input logic [31:0] inst);
        return inst[31:26];
    endfunction

    function automatic logic [5:0] funct(input logic [31:0] inst);
        return inst[5:0];
    endfunction

    function automatic logic is_syscall(input logic [31:0] inst);
        return inst == INST_SYSCALL;
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// PC register with a one-deep pending-redirect slot and the next-PC mux.
// A redirect seen under stall is parked and applied on the first free edge.
module if_pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter int          ADRS_W   = mips_pkg::ADRS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              hold,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADRS_W-1:0] rom_adrs,
    output logic [31:0]       pc4
);

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] target;
    logic [31:0] pend_pc;
    logic        pend_valid;

    assign pc4      = pc + 32'd4;
    assign rom_adrs = pc[ADRS_W+1:2];
    assign target   = redirect_pc & ~32'd3;

    always_comb begin
        next_pc = pc4;
        if (redirect_valid) begin
            next_pc = target;
        end else if (pend_valid) begin
            next_pc = pend_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else if (!hold) begin
            if (stall) begin
                // newest redirect under stall replaces any older one
                if (redirect_valid) begin
                    pend_valid <= 1'b1;
                    pend_pc    <= target;
                end
            end else begin
                pc         <= next_pc;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC/redirect logic plus the IF/ID register.
// Define SYSCALL_HALT_EN to stop fetching after a syscall is captured.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          ADRS_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADRS_W-1:0] rom_adrs,
    input  logic [31:0]       rom_dout,
    output logic [31:0]       ifid_inst,
    output logic [31:0]       ifid_pc4,
    output logic              ifid_valid,
    output logic              halted
);

    logic [31:0] pc4;
    logic        hold_pc;
    logic        halted_q;

`ifdef SYSCALL_HALT_EN
    logic capture_sys;

    assign capture_sys = !halted_q && !stall && is_syscall(rom_dout);
    assign hold_pc     = halted_q || capture_sys;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (capture_sys) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign hold_pc  = 1'b0;
    assign halted_q = 1'b0;
`endif

    assign halted = halted_q;

    if_pc_reg #(
        .RESET_PC (RESET_PC),
        .ADRS_W   (ADRS_W)
    ) u_pc (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .hold           (hold_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_adrs       (rom_adrs),
        .pc4            (pc4)
    );

    // the word fetched alongside a redirect is the delay slot and is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_inst  <= INST_NOP;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else if (halted_q) begin
            ifid_inst  <= INST_NOP;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_inst  <= rom_dout;
            ifid_pc4   <= pc4;
            ifid_valid <= 1'b1;
        end
    end

endmodule
